// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: line, command and status signals between a PS/2 host transmitter and its user
interface ps2_host_tx_if;
  logic       ce;
  logic [1:0] ps2;
  logic       clkLow;
  logic       datLow;
  logic [7:0] data;
  logic       start;
  logic       busy;
  logic       done;
  logic       ack;
  logic       error;
  modport master (
    output ce, ps2, data, start,
    input  clkLow, datLow, busy, done, ack, error
  );
  modport slave (
    input  ce, ps2, data, start,
    output clkLow, datLow, busy, done, ack, error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with filtered device clock and ack capture
module ps2_host_tx #(
  parameter int INHIBIT = 128,
  parameter int TIMEOUT = 16384,
  parameter int FILTER  = 8
) (
  input logic          clock,
  input logic          reset,
  ps2_host_tx_if.slave bus
);
  localparam int CW = $clog2(INHIBIT);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, INHIBIT_S, RELEASE_S, DATA_S, ACK_S, WAITIDLE_S} state_t;
  state_t            state_q, state_d;
  logic [FILTER-1:0] filt_q, filt_d;
  logic              clean_q, clean_d, fall_q, fall_d, dsmp_q, dsmp_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              clk_low_q, clk_low_d, dat_low_q, dat_low_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, ack_q, ack_d;
  // state register: reset releases both lines at once and presets the filter to an idle-high clock
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      filt_q    <= '1;
      clean_q   <= 1'b1;
      fall_q    <= 1'b0;
      dsmp_q    <= 1'b1;
      shift_q   <= '0;
      par_q     <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      tmo_q     <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      clean_q   <= clean_d;
      fall_q    <= fall_d;
      dsmp_q    <= dsmp_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tmo_q     <= tmo_d;
      clk_low_q <= clk_low_d;
      dat_low_q <= dat_low_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
    end
  end
  // next state: filter and frame sequencing advance on ce; done/error fall back the very next clock
  always_comb begin
    state_d   = state_q;
    filt_d    = filt_q;
    clean_d   = clean_q;
    fall_d    = fall_q;
    dsmp_d    = dsmp_q;
    shift_d   = shift_q;
    par_d     = par_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tmo_d     = tmo_q;
    clk_low_d = clk_low_q;
    dat_low_d = dat_low_q;
    busy_d    = busy_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (bus.ce) begin
      filt_d  = {filt_q[FILTER-2:0], bus.ps2[0]};
      clean_d = &filt_d ? 1'b1 : (|filt_d ? clean_q : 1'b0);
      fall_d  = clean_q & ~clean_d;
      dsmp_d  = bus.ps2[1];
      case (state_q)
        IDLE: if (bus.start) begin
          shift_d   = bus.data;
          par_d     = ~^bus.data;
          busy_d    = 1'b1;
          clk_low_d = 1'b1;
          ack_d     = 1'b0;
          cnt_d     = '0;
          state_d   = INHIBIT_S;
        end
        INHIBIT_S: if (cnt_q == CW'(INHIBIT - 1)) begin
          dat_low_d = 1'b1;
          state_d   = RELEASE_S;
        end else cnt_d = cnt_q + CW'(1);
        RELEASE_S: begin
          clk_low_d = 1'b0;
          bit_d     = '0;
          tmo_d     = '0;
          state_d   = DATA_S;
        end
        default: begin
          tmo_d = fall_q ? '0 : tmo_q + TW'(1);
          if (!fall_q && tmo_q == TW'(TIMEOUT - 1)) begin
            clk_low_d = 1'b0;
            dat_low_d = 1'b0;
            busy_d    = 1'b0;
            ack_d     = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            state_d   = IDLE;
          end else if (state_q == DATA_S && fall_q) begin
            dat_low_d = bit_q[3] ? (bit_q[0] ? 1'b0 : ~par_q) : ~shift_q[bit_q[2:0]];
            bit_d     = bit_q == 4'd9 ? bit_q : bit_q + 4'd1;
            state_d   = bit_q == 4'd9 ? ACK_S : DATA_S;
          end else if (state_q == ACK_S && fall_q) begin
            ack_d   = ~dsmp_q;
            state_d = WAITIDLE_S;
          end else if (state_q == WAITIDLE_S && clean_q && dsmp_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = ~ack_q;
            state_d = IDLE;
          end
        end
      endcase
    end
  end
  // outputs: straight from registers so the lines never see a combinational path from inputs
  always_comb begin
    bus.clkLow = clk_low_q;
    bus.datLow = dat_low_q;
    bus.busy   = busy_q;
    bus.done   = done_q;
    bus.error  = err_q;
    bus.ack    = ack_q;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven frames against a device clock model, plus timeout and reset sequences
module tb_ps2_host_tx;
  localparam int INH = 128;
  localparam int TMO = 500;
  typedef struct {
    logic [7:0] d;
    logic       ack_low;
    int         poke;
    logic [9:0] dl;
    logic       exp_ack;
    logic       exp_err;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic mon_clr = 1'b0;
  int total = 0;
  int bad = 0;
  int ce_cnt = 0;
  int hi_ce, both_ce, n_done, d_ce, dbl, stray;
  logic d_ack, d_err, prev_done;
  vec_t tv[5];
  ps2_host_tx_if bus ();
  ps2_host_tx #(.INHIBIT(INH), .TIMEOUT(TMO), .FILTER(8)) dut (.clock(clock), .reset(reset), .bus(bus));
  assign bus.ps2 = {~bus.datLow & ~dev_dat_low, ~bus.clkLow & ~dev_clk_low};
  always #5 clock = ~clock;
  initial begin
    bus.ce = 1'b0;
    forever begin
      @(posedge clock);
      #1 bus.ce = ~bus.ce;
    end
  end
  always @(posedge clock) begin
    if (bus.ce) ce_cnt <= ce_cnt + 1;
    prev_done <= bus.done;
    if (mon_clr) begin
      hi_ce <= 0; both_ce <= 0; n_done <= 0; d_ce <= 0; dbl <= 0; stray <= 0;
      d_ack <= 1'b0; d_err <= 1'b0;
    end else begin
      if (bus.ce && bus.clkLow) hi_ce <= hi_ce + 1;
      if (bus.ce && bus.clkLow && bus.datLow) both_ce <= both_ce + 1;
      if (bus.done) begin
        n_done <= n_done + 1; d_ack <= bus.ack; d_err <= bus.error; d_ce <= ce_cnt;
      end
      if (bus.done && prev_done) dbl <= dbl + 1;
      if (bus.error && !bus.done) stray <= stray + 1;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic wait_ce(input int n);
    repeat (2 * n) @(posedge clock);
    #1;
  endtask
  task automatic clr_mon();
    @(posedge clock);
    #1 mon_clr = 1'b1;
    @(posedge clock);
    #1 mon_clr = 1'b0;
  endtask
  task automatic start_tx(input logic [7:0] d);
    int n = 0;
    @(posedge clock);
    #1 bus.data = d;
    bus.start = 1'b1;
    while (bus.busy !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1 bus.start = 1'b0;
    chk("start_accept", bus.busy, 1'b1);
  endtask
  task automatic dev_run(input logic ack_low, input int poke, input int stop_at,
                         output logic [9:0] seen, output int bb);
    int n = 0;
    seen = '0;
    bb = 0;
    while (bus.clkLow !== 1'b0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("release_wait", n < 2000, 1'b1);
    wait_ce(20);
    chk("start_bit_held", bus.datLow, 1'b1);
    for (int i = 0; i < 11; i++) begin
      dev_clk_low = 1'b1;
      if (i == poke) begin
        bus.data = 8'h55;
        bus.start = 1'b1;
        repeat (2) @(posedge clock);
        #1 bus.start = 1'b0;
      end
      wait_ce(20);
      if (i < 10) begin
        seen[i] = bus.datLow;
        if (bus.busy !== 1'b1) bb++;
      end
      if (i == stop_at) return;
      dev_clk_low = 1'b0;
      if (i == 9) dev_dat_low = ack_low;
      wait_ce(20);
    end
    dev_dat_low = 1'b0;
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    logic [9:0] seen;
    int bb;
    int n = 0;
    clr_mon();
    start_tx(v.d);
    dev_run(v.ack_low, v.poke, 99, seen, bb);
    while (n_done == 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    repeat (10) @(negedge clock);
    chk({nm, "_datlow_seq"}, seen, v.dl);
    chk({nm, "_done_count"}, n_done, 1);
    chk({nm, "_ack"}, d_ack, v.exp_ack);
    chk({nm, "_error"}, d_err, v.exp_err);
    chk({nm, "_inhibit_ce"}, hi_ce, INH + 1);
    chk({nm, "_start_lead_ce"}, both_ce, 1);
    chk({nm, "_busy_gaps"}, bb, 0);
    chk({nm, "_done_width"}, dbl, 0);
    chk({nm, "_stray_error"}, stray, 0);
    chk({nm, "_idle_lines"}, {bus.clkLow, bus.datLow, bus.busy}, 3'b000);
  endtask
  initial begin
    logic [9:0] seen;
    int bb, n, rel;
    bus.data = 8'h00;
    bus.start = 1'b0;
    tv[0] = '{8'hED, 1'b1, 99, 10'h012, 1'b1, 1'b0};
    tv[1] = '{8'h07, 1'b1, 3,  10'h1F8, 1'b1, 1'b0};
    tv[2] = '{8'h00, 1'b1, 99, 10'h0FF, 1'b1, 1'b0};
    tv[3] = '{8'hFF, 1'b1, 99, 10'h000, 1'b1, 1'b0};
    tv[4] = '{8'hA5, 1'b0, 99, 10'h05A, 1'b0, 1'b1};
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {bus.clkLow, bus.datLow, bus.busy, bus.done, bus.error, bus.ack}, 6'b0);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) run_vec(tv[i], $sformatf("vec%0d", i));
    clr_mon();
    start_tx(8'h3C);
    n = 0;
    while (bus.clkLow !== 1'b0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_release_wait", n < 1000, 1'b1);
    rel = ce_cnt;
    n = 0;
    while (n_done == 0 && n < 2 * TMO + 100) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_latency_ce", d_ce - rel, TMO);
    chk("tmo_error", d_err, 1'b1);
    chk("tmo_ack", d_ack, 1'b0);
    chk("tmo_lines", {bus.clkLow, bus.datLow, bus.busy}, 3'b000);
    clr_mon();
    start_tx(8'hFF);
    dev_run(1'b1, 99, 4, seen, bb);
    chk("rst_pre_bits", seen[4:0], 5'b00000);
    chk("rst_pre_busy", bus.busy, 1'b1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_lines", {bus.clkLow, bus.datLow, bus.busy}, 3'b000);
    reset = 1'b0;
    dev_clk_low = 1'b0;
    wait_ce(20);
    chk("rst_no_done", n_done, 0);
    run_vec(tv[3], "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
